// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// The LSU is the slave; the MEM stage and the data memory form the master side.
interface load_store_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;

    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_misalign;

    logic [WIDTH-1:0] mem_addr;
    logic             mem_re;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  mem_rdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_misalign,
        output mem_addr,
        output mem_re,
        output mem_we,
        output mem_wdata
    );

    modport master (
        output req_valid,
        output req_we,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output mem_rdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_misalign,
        input  mem_addr,
        input  mem_re,
        input  mem_we,
        input  mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory without byte enables.
// Sub-word stores use read-modify-write; bad accesses never reach memory.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [2:0]       op_f3;
    logic [WIDTH-1:0] op_addr;
    logic [WIDTH-1:0] op_wdata;

    logic [WIDTH-1:0] wbuf;
    logic [WIDTH-1:0] wbuf_nx;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_nx;
    logic             mis_q;
    logic             mis_nx;

    logic             accept;
    logic             req_err;
    logic [4:0]       sh;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] merged;

    assign accept = bus.req_valid & (state == IDLE);

    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = bus.req_addr[0];
            3'b010:  req_err = |bus.req_addr[1:0];
            3'b100:  req_err = bus.req_we;
            3'b101:  req_err = bus.req_we | bus.req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // Lane shift; halfwords are aligned so the same shift selects them.
    assign sh      = {op_addr[1:0], 3'b000};
    assign shifted = bus.mem_rdata >> sh;

    always_comb begin
        ld_data = shifted;
        case (op_f3)
            3'b000:  ld_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  ld_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        mask   = (op_f3[0] ? WIDTH'(16'hFFFF) : WIDTH'(8'hFF)) << sh;
        merged = (bus.mem_rdata & ~mask) | ((op_wdata << sh) & mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_f3    <= 3'b000;
            op_addr  <= '0;
            op_wdata <= '0;
            wbuf     <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            wbuf    <= wbuf_nx;
            rdata_q <= rdata_nx;
            mis_q   <= mis_nx;
            if (accept) begin
                op_f3    <= bus.req_funct3;
                op_addr  <= bus.req_addr;
                op_wdata <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        wbuf_nx       = wbuf;
        rdata_nx      = rdata_q;
        mis_nx        = mis_q;
        bus.req_ready = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (req_err) begin
                        rdata_nx = '0;
                        mis_nx   = 1'b1;
                        state_nx = RESP;
                    end else if (!bus.req_we) begin
                        state_nx = LOAD;
                    end else if (bus.req_funct3 == 3'b010) begin
                        wbuf_nx  = bus.req_wdata;
                        state_nx = WRITE;
                    end else begin
                        state_nx = RMW_RD;
                    end
                end
            end
            LOAD: begin
                bus.mem_re = 1'b1;
                rdata_nx   = ld_data;
                mis_nx     = 1'b0;
                state_nx   = RESP;
            end
            RMW_RD: begin
                bus.mem_re = 1'b1;
                wbuf_nx    = merged;
                state_nx   = WRITE;
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                rdata_nx   = '0;
                mis_nx     = 1'b0;
                state_nx   = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_misalign = mis_q;
    assign bus.mem_addr     = {op_addr[WIDTH-1:2], 2'b00};
    assign bus.mem_wdata    = wbuf;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic checked
// against a byte-array memory model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    load_store_unit_if #(.WIDTH(32)) bus ();

    load_store_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [64];
    logic [7:0]  ref_mem [256];

    int compared   = 0;
    int mismatched = 0;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit exp_err(input bit we, input logic [2:0] f3, input int a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        int sz;
        logic [31:0] v;
        sz = acc_size(f3);
        v  = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
        for (int i = 0; i < acc_size(f3); i++) ref_mem[a + i] = 8'(wd >> (8 * i));
    endtask

    task automatic drive(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        bit err;
        int ai, lat, exp_lat, re_n, we_n, we_at, both, rdy_busy;
        logic [31:0] exp_data;
        ai       = int'(a[7:0]);
        err      = exp_err(we, f3, ai);
        exp_lat  = err ? 1 : ((!we || f3 == 3'd2) ? 2 : 3);
        exp_data = (err || we) ? 32'h0 : ref_load(f3, ai);
        @(negedge clk);
        check({tag, " ready_idle"}, bus.req_ready, 1'b1);
        drive(we, f3, a, wd);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1; re_n = 0; we_n = 0; we_at = 0; both = 0; rdy_busy = 0;
        while (!bus.rsp_valid && lat < 8) begin
            re_n += int'(bus.mem_re);
            we_n += int'(bus.mem_we);
            if (bus.mem_we && we_at == 0) we_at = lat;
            both     += int'(bus.mem_re & bus.mem_we);
            rdy_busy += int'(bus.req_ready);
            @(posedge clk);
            #1;
            lat++;
        end
        re_n     += int'(bus.mem_re);
        we_n     += int'(bus.mem_we);
        rdy_busy += int'(bus.req_ready);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, bus.rsp_rdata, exp_data);
        check({tag, " misalign"}, bus.rsp_misalign, err);
        check({tag, " re_cycles"}, 32'(re_n), (!err && (!we || f3 != 3'd2)) ? 32'd1 : 32'd0);
        check({tag, " we_cycles"}, 32'(we_n), (!err && we) ? 32'd1 : 32'd0);
        check({tag, " we_cycle_at"}, 32'(we_at), (!err && we) ? 32'(exp_lat - 1) : 32'd0);
        check({tag, " re_and_we"}, 32'(both), 32'd0);
        check({tag, " ready_busy"}, 32'(rdy_busy), 32'd0);
        if (!err && we) ref_store(f3, ai, wd);
        @(posedge clk);
        #1;
        check({tag, " rsp_pulse"}, bus.rsp_valid, 1'b0);
        check({tag, " rdata_hold"}, bus.rsp_rdata, exp_data);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"}, bus.req_ready, 1'b1);
        check({tag, " rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, " misalign"}, bus.rsp_misalign, 1'b0);
        check({tag, " mem_re"}, bus.mem_re, 1'b0);
        check({tag, " mem_we"}, bus.mem_we, 1'b0);
        check({tag, " rdata"}, bus.rsp_rdata, 32'h0);
        check({tag, " mem_addr"}, bus.mem_addr, 32'h0);
        check({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
    endtask

    initial begin
        int acc, rsps, busy_bad, extra;
        logic [31:0] b2b_exp;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, "t1_sw");
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "t1_lw");
        check("t1_lw value", bus.rsp_rdata, 32'hDEAD_BEEF);

        do_req(1'b1, 3'd2, 32'h10, 32'h1122_3344, "t2_sw");
        do_req(1'b1, 3'd0, 32'h11, 32'h1234_56AB, "t2_sb");
        check("t2_sb memory", mem[4], 32'h1122_AB44);
        do_req(1'b0, 3'd0, 32'h11, 32'h0, "t2_lb");
        check("t2_lb value", bus.rsp_rdata, 32'hFFFF_FFAB);
        do_req(1'b0, 3'd4, 32'h11, 32'h0, "t2_lbu");
        check("t2_lbu value", bus.rsp_rdata, 32'h0000_00AB);

        do_req(1'b1, 3'd1, 32'h12, 32'hCAFE_8001, "t3_sh");
        check("t3_sh memory", mem[4], 32'h8001_AB44);
        do_req(1'b0, 3'd1, 32'h12, 32'h0, "t3_lh");
        check("t3_lh value", bus.rsp_rdata, 32'hFFFF_8001);
        do_req(1'b0, 3'd5, 32'h12, 32'h0, "t3_lhu");
        check("t3_lhu value", bus.rsp_rdata, 32'h0000_8001);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, "t3_lb");
        check("t3_lb value", bus.rsp_rdata, 32'hFFFF_FF80);

        do_req(1'b0, 3'd2, 32'h13, 32'h0, "t4_lw_mis");
        do_req(1'b1, 3'd1, 32'h15, 32'h0000_7777, "t4_sh_mis");
        do_req(1'b0, 3'd3, 32'h10, 32'h0, "t4_f3_011");
        do_req(1'b1, 3'd4, 32'h10, 32'h0, "t4_sbu_ill");
        check("t4 memory", mem[4], 32'h8001_AB44);

        do_req(1'b0, 3'd2, 32'h10, 32'h0, "t5_pre");
        @(negedge clk);
        drive(1'b1, 3'd0, 32'h11, 32'h0000_0055);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("t5 in_rmw_rd", bus.mem_re, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_rmw");
        @(negedge clk);
        rst = 1'b0;
        check("t5 rmw memory", mem[4], 32'h8001_AB44);

        @(negedge clk);
        drive(1'b1, 3'd2, 32'h10, 32'h1234_5678);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("t5 in_write", bus.mem_we, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_wr");
        @(posedge clk);
        #1;
        check("t5 wr memory", mem[4], 32'h8001_AB44);
        @(negedge clk);
        rst = 1'b0;
        check("t5 ready_after", bus.req_ready, 1'b1);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "t5_post_lw");
        check("t5_post_lw value", bus.rsp_rdata, 32'h8001_AB44);

        b2b_exp  = ref_load(3'd2, 32'h10);
        acc      = 0;
        rsps     = 0;
        busy_bad = 0;
        @(negedge clk);
        drive(1'b0, 3'd2, 32'h10, 32'h0);
        for (int c = 0; c < 30 && rsps < 3; c++) begin
            if (acc == 3) bus.req_valid = 1'b0;
            else if (bus.req_ready) acc++;
            @(posedge clk);
            #1;
            if ((bus.mem_re || bus.rsp_valid) && bus.req_ready) busy_bad++;
            if (bus.rsp_valid) begin
                rsps++;
                check("t6 rdata", bus.rsp_rdata, b2b_exp);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            extra += int'(bus.rsp_valid);
        end
        check("t6 accepts", 32'(acc), 32'd3);
        check("t6 responses", 32'(rsps), 32'd3);
        check("t6 ready_busy", 32'(busy_bad), 32'd0);
        check("t6 extra_rsp", 32'(extra), 32'd0);

        for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 255)), $urandom, "rand");
        end

        for (int w = 0; w < 64; w++) begin
            check("final_mem", mem[w],
                  {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
